// File: rtl/sha3_lane_serializer.sv
// Captures a 25-lane Keccak state on `sample` and streams it out one 64-bit lane per valid/ready handshake.
// Optional build macro SHA3_LANE_BYTESWAP_EN byte-reverses lane_data for big-endian consumers.

module sha3_lane_serializer_chk #(
  parameter logic [4:0] LAST_IDX = 5'd24
) (
  input logic        clk,
  input logic        rst_n,
  input logic        lane_valid,
  input logic        lane_ready,
  input logic        lane_last,
  input logic        busy,
  input logic [63:0] lane_data,
  input logic [4:0]  lane_idx
);

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lane_valid && !lane_ready) |=> (lane_valid && $stable(lane_data) && $stable(lane_idx)));

  a_last_flag: assert property (@(posedge clk) disable iff (!rst_n)
    lane_last == (lane_valid && (lane_idx == LAST_IDX)));

  a_busy_valid: assert property (@(posedge clk) disable iff (!rst_n)
    busy == lane_valid);

endmodule

module sha3_lane_serializer #(
  parameter int OUT_LANES = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] isa [0:4],
  input  logic [63:0] isb [0:4],
  input  logic [63:0] isc [0:4],
  input  logic [63:0] isd [0:4],
  input  logic [63:0] ise [0:4],
  input  logic        sample,
  output logic [63:0] lane_data,
  output logic [4:0]  lane_idx,
  output logic        lane_valid,
  input  logic        lane_ready,
  output logic        lane_last,
  output logic        busy,
  output logic        overrun
);

  localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  logic [63:0] lanes_r    [0:24];
  logic [63:0] in_lanes_s [0:24];
  logic        hs_s;
  logic        final_hs_s;
  logic        capture_s;
  logic [4:0]  nxt_idx_s;

  function automatic logic [63:0] lane_fmt(input logic [63:0] v);
    logic [63:0] r;
`ifdef SHA3_LANE_BYTESWAP_EN
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = v[56-8*b +: 8];
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // Flatten the five input groups into lane order k = 5*g + e.
  always_comb begin
    for (int e = 0; e < 5; e++) begin
      in_lanes_s[e]      = isa[e];
      in_lanes_s[5 + e]  = isb[e];
      in_lanes_s[10 + e] = isc[e];
      in_lanes_s[15 + e] = isd[e];
      in_lanes_s[20 + e] = ise[e];
    end
  end

  // Handshake decode; a sample is taken in IDLE or on the final-lane handshake.
  always_comb begin
    hs_s       = lane_valid && lane_ready;
    final_hs_s = hs_s && (lane_idx == LAST_IDX);
    nxt_idx_s  = lane_idx + 5'd1;
    if (state_r == IDLE) begin
      capture_s = sample;
    end else begin
      capture_s = sample && final_hs_s;
    end
  end

  // Capture/stream FSM with registered lane outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      for (int k = 0; k < 25; k++) begin
        lanes_r[k] <= 64'd0;
      end
      lane_data  <= 64'd0;
      lane_idx   <= 5'd0;
      lane_valid <= 1'b0;
      lane_last  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sample && (state_r == SEND) && !final_hs_s) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE, SEND: begin
          if (capture_s) begin
            for (int k = 0; k < 25; k++) begin
              lanes_r[k] <= in_lanes_s[k];
            end
            state_r    <= SEND;
            lane_idx   <= 5'd0;
            lane_data  <= lane_fmt(in_lanes_s[0]);
            lane_valid <= 1'b1;
            lane_last  <= (LAST_IDX == 5'd0);
            busy       <= 1'b1;
          end else if (final_hs_s) begin
            state_r    <= IDLE;
            lane_idx   <= 5'd0;
            lane_data  <= 64'd0;
            lane_valid <= 1'b0;
            lane_last  <= 1'b0;
            busy       <= 1'b0;
          end else if (hs_s) begin
            lane_idx  <= nxt_idx_s;
            lane_data <= lane_fmt(lanes_r[nxt_idx_s]);
            lane_last <= (nxt_idx_s == LAST_IDX);
          end
        end
        default: begin
          state_r    <= IDLE;
          lane_valid <= 1'b0;
          lane_last  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  sha3_lane_serializer_chk #(
    .LAST_IDX (LAST_IDX)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .lane_last  (lane_last),
    .busy       (busy),
    .lane_data  (lane_data),
    .lane_idx   (lane_idx)
  );

endmodule

// File: tb/tb_sha3_lane_serializer.sv
// Self-checking bench for sha3_lane_serializer: a full-state instance (25 lanes) and a digest instance (4 lanes).
module tb_sha3_lane_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] isa [0:4];
  logic [63:0] isb [0:4];
  logic [63:0] isc [0:4];
  logic [63:0] isd [0:4];
  logic [63:0] ise [0:4];
  logic        smp, lr, smp4, lr4;
  logic [63:0] ld, ld4;
  logic [4:0]  li, li4;
  logic        lv, ll, bz, ov, lv4, ll4, bz4, ov4;

  int checks = 0;
  int failures = 0;
  logic [63:0] st [25];
  logic [63:0] first [25];

  sha3_lane_serializer #(.OUT_LANES(25)) dut (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(smp), .lane_data(ld), .lane_idx(li), .lane_valid(lv), .lane_ready(lr),
    .lane_last(ll), .busy(bz), .overrun(ov)
  );

  sha3_lane_serializer #(.OUT_LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(smp4), .lane_data(ld4), .lane_idx(li4), .lane_valid(lv4), .lane_ready(lr4),
    .lane_last(ll4), .busy(bz4), .overrun(ov4)
  );

  function automatic logic [63:0] host_view(input logic [63:0] v);
`ifdef SHA3_LANE_BYTESWAP_EN
    return {<<8{v}};
`else
    return v;
`endif
  endfunction

  // Lane k sits in group k/5 (a..e), element k%5.
  task automatic drive_state();
    for (int k = 0; k < 25; k++) begin
      case (k / 5)
        0: isa[k % 5] = st[k];
        1: isb[k % 5] = st[k];
        2: isc[k % 5] = st[k];
        3: isd[k % 5] = st[k];
        default: ise[k % 5] = st[k];
      endcase
    end
  endtask

  task automatic random_state();
    for (int k = 0; k < 25; k++) st[k] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; smp = 1'b0; smp4 = 1'b0; lr = 1'b0; lr4 = 1'b0;
    for (int k = 0; k < 25; k++) st[k] = 64'd0;
    drive_state();
    repeat (3) @(negedge clk);
    checks++;
    if ({lv, ll, bz, ov, li} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl got v=%b l=%b b=%b o=%b idx=%0d required all 0", lv, ll, bz, ov, li);
    end
    checks++;
    if (ld !== 64'd0) begin failures++; $display("FAIL reset_data got=%h required=0", ld); end
    checks++;
    if ({lv4, ll4, bz4, ov4, li4} !== 9'd0 || ld4 !== 64'd0) begin
      failures++; $display("FAIL reset_dut4 got v=%b idx=%0d data=%h required 0", lv4, li4, ld4);
    end
    rst_n = 1'b1;
    lr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (lv !== 1'b0 || bz !== 1'b0) begin
      failures++; $display("FAIL idle_ready_ignored got v=%b b=%b required 0", lv, bz);
    end
  endtask

  task automatic test_full_stream();
    for (int k = 0; k < 25; k++) st[k] = 64'h0100_0000_0000_0000 + 64'(k);
    drive_state();
    smp = 1'b1; lr = 1'b1;
    @(negedge clk);
    smp = 1'b0;
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (lv !== 1'b1 || bz !== 1'b1 || li !== 5'(k) || ld !== host_view(st[k])) begin
        failures++; $display("FAIL full_lane k=%0d got v=%b b=%b idx=%0d data=%h required v=1 b=1 data=%h",
                             k, lv, bz, li, ld, host_view(st[k]));
      end
      checks++;
      if (ll !== (k == 24)) begin failures++; $display("FAIL full_last k=%0d got=%b", k, ll); end
      if (k == 7) begin
        checks++;
        if (ld !== host_view(isb[2])) begin
          failures++; $display("FAIL lane7_map got=%h required=%h", ld, host_view(isb[2]));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (lv !== 1'b0 || bz !== 1'b0) begin failures++; $display("FAIL full_end got v=%b b=%b required 0", lv, bz); end
  endtask

  task automatic test_short_digest();
    random_state();
    for (int e = 0; e < 5; e++) st[e] = 64'hA0 + 64'(e);
    drive_state();
    smp4 = 1'b1; lr4 = 1'b1;
    @(negedge clk);
    smp4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (lv4 !== 1'b1 || li4 !== 5'(k) || ld4 !== host_view(st[k]) || ll4 !== (k == 3)) begin
        failures++; $display("FAIL digest_lane k=%0d got v=%b idx=%0d data=%h last=%b required data=%h",
                             k, lv4, li4, ld4, ll4, host_view(st[k]));
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (lv4 !== 1'b0 || bz4 !== 1'b0) begin
        failures++; $display("FAIL digest_idle c=%0d got v=%b b=%b required 0", c, lv4, bz4);
      end
      @(negedge clk);
    end
    lr4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int n = 0;
    int cyc = 0;
    logic [63:0] prev_d = 64'd0;
    logic [4:0]  prev_i = 5'd0;
    logic stalled = 1'b0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    random_state();
    drive_state();
    smp = 1'b1; lr = 1'b0;
    @(negedge clk);
    smp = 1'b0;
    while (n < 25 && cyc < 400) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(n) || ld !== host_view(st[n])) begin
        failures++; $display("FAIL bp_lane n=%0d got v=%b idx=%0d data=%h required data=%h",
                             n, lv, li, ld, host_view(st[n]));
      end
      if (stalled) begin
        checks++;
        if (ld !== prev_d || li !== prev_i) begin
          failures++; $display("FAIL bp_stable got idx=%0d data=%h required idx=%0d data=%h", li, ld, prev_i, prev_d);
        end
      end
      lr = (cyc < 6) ? pat[cyc] : 1'($urandom_range(0, 1));
      prev_d = ld; prev_i = li; stalled = !lr;
      if (lr) n++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (n != 25) begin failures++; $display("FAIL bp_count got=%0d required=25", n); end
    checks++;
    if (lv !== 1'b0) begin failures++; $display("FAIL bp_end got v=%b required 0", lv); end
    lr = 1'b1;
  endtask

  task automatic test_back_to_back();
    random_state();
    drive_state();
    smp = 1'b1; lr = 1'b1;
    @(negedge clk);
    smp = 1'b0;
    first = st;
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(k) || ld !== host_view(first[k])) begin
        failures++; $display("FAIL b2b_first k=%0d got idx=%0d data=%h required data=%h", k, li, ld, host_view(first[k]));
      end
      if (k == 24) begin
        for (int j = 0; j < 25; j++) st[j] = 64'hFFFF_FFFF_FFFF_FFFF;
        drive_state();
        smp = 1'b1;
      end
      @(negedge clk);
      smp = 1'b0;
    end
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(k) || ld !== 64'hFFFF_FFFF_FFFF_FFFF || ov !== 1'b0) begin
        failures++; $display("FAIL b2b_second k=%0d got v=%b idx=%0d data=%h ovr=%b required all-ones ovr=0", k, lv, li, ld, ov);
      end
      @(negedge clk);
    end
    checks++;
    if (lv !== 1'b0) begin failures++; $display("FAIL b2b_end got v=%b required 0", lv); end
  endtask

  task automatic test_overrun();
    random_state();
    drive_state();
    smp = 1'b1; lr = 1'b1;
    @(negedge clk);
    smp = 1'b0;
    first = st;
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(k) || ld !== host_view(first[k])) begin
        failures++; $display("FAIL ovr_lane k=%0d got idx=%0d data=%h required data=%h", k, li, ld, host_view(first[k]));
      end
      checks++;
      if (ov !== (k > 10)) begin failures++; $display("FAIL ovr_flag k=%0d got=%b required=%b", k, ov, (k > 10)); end
      if (k == 10) begin
        random_state();
        drive_state();
        smp = 1'b1;
      end
      @(negedge clk);
      smp = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (lv !== 1'b0 || ov !== 1'b1) begin failures++; $display("FAIL ovr_sticky got v=%b ovr=%b required v=0 ovr=1", lv, ov); end
  endtask

  task automatic test_async_reset();
    logic [63:0] swapped;
    random_state();
    drive_state();
    smp = 1'b1; lr = 1'b1;
    @(negedge clk);
    smp = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(k) || ld !== host_view(st[k])) begin
        failures++; $display("FAIL ar_lane k=%0d got idx=%0d data=%h required data=%h", k, li, ld, host_view(st[k]));
      end
      if (k < 12) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lv, ll, bz, ov, li} !== 9'd0 || ld !== 64'd0) begin
      failures++; $display("FAIL ar_immediate got v=%b l=%b b=%b o=%b idx=%0d data=%h required 0", lv, ll, bz, ov, li, ld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    random_state();
    st[0] = 64'h0102030405060708;
    drive_state();
    smp = 1'b1;
    @(negedge clk);
    smp = 1'b0;
`ifdef SHA3_LANE_BYTESWAP_EN
    swapped = 64'h0807060504030201;
`else
    swapped = 64'h0102030405060708;
`endif
    checks++;
    if (ld !== swapped) begin failures++; $display("FAIL byte_order got=%h required=%h", ld, swapped); end
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (lv !== 1'b1 || li !== 5'(k) || ld !== host_view(st[k])) begin
        failures++; $display("FAIL ar_restream k=%0d got v=%b idx=%0d data=%h required data=%h", k, lv, li, ld, host_view(st[k]));
      end
      @(negedge clk);
    end
    checks++;
    if (lv !== 1'b0 || bz !== 1'b0) begin failures++; $display("FAIL ar_end got v=%b b=%b required 0", lv, bz); end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_short_digest();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
